pulse_req_sender: RTL
=====================

Name: pulse_req_sender

Overview:
- Single-clock, fast-domain initiator for the pulse-synchronizer handshake.
- Queues local event pulses and issues each one as a level request toward the slow-domain synchronizer.
- Holds each request until the returned single-cycle acknowledge pulse arrives, or until a timeout expires.
- Enforces a low gap between requests so each rising edge is seen by the far side.

Parameters:
CNT_W, 2, width of pending-event counter; max pending = 2^CNT_W-1
GAP_CYC, 4, cycles o_req is held low between consecutive requests (>=1)
TIMEOUT, 16, max cycles o_req stays high awaiting ack (>=2)
TO_W, 8, width of timeout/gap counter (must hold max(TIMEOUT,GAP_CYC))

Ports:
f_clk  in  1  clock
frst_n  in  1  asynchronous active-low reset
i_evt  in  1  event pulse, one event per high cycle
i_ack  in  1  single-cycle acknowledge pulse returned from the synchronizer
o_req  out  1  request level to the synchronizer
o_busy  out  1  high when state != IDLE
o_pend  out  CNT_W  events queued but not yet issued
o_done  out  1  1-cycle pulse: request acknowledged
o_timeout  out  1  1-cycle pulse: request abandoned, no ack
o_ovf  out  1  1-cycle pulse: event dropped, queue full

Behaviour:
Interface and reset:
- One clock, f_clk. Reset frst_n is asynchronous and active-low.
- Reset forces state IDLE and clears all counters. All outputs are 0 at reset.
- All outputs are registered. Reset asserted mid-operation drops any request and all pending events immediately; no o_done or o_timeout is produced.

States (IDLE, REQ, GAP):
- IDLE: if (o_pend!=0 || i_evt), then "issue" occurs: next state REQ, timer cleared. Otherwise stay in IDLE.
- REQ: o_req=1 and the timer increments each cycle.
  - If i_ack=1: next state GAP and o_done=1 on the next cycle.
  - Else if timer==TIMEOUT-1: next state GAP and o_timeout=1 on the next cycle.
  - Ack and timeout in the same cycle: ack wins, o_done only.
- GAP: o_req=0. Stay exactly GAP_CYC cycles, then IDLE.
- Timer reuse: one TO_W counter serves as both the REQ timer and the GAP counter, cleared on each state entry.

Request timing:
- o_req rises the cycle after issue and falls the cycle after ack or timeout.
- Latency from i_evt in IDLE with empty queue to o_req high: 1 cycle.
- Minimum spacing between o_req rising edges: 1 + GAP_CYC + 1 cycles.

Pending counter:
- Update rule: pend_next = pend + accept - consume.
  - accept = i_evt && !(issue from IDLE with pend==0).
  - consume = issue && pend!=0.
- An i_evt that itself triggers issue from an empty queue is not counted.
- If accept && pend==2^CNT_W-1 && !consume: the event is dropped, o_ovf=1 next cycle, pend unchanged.
- Accept and consume in the same cycle: pend unchanged, no overflow.
- pend never wraps in either direction.

Ack filtering:
- i_ack received while in IDLE or GAP is ignored: no o_done, no state change.
- i_ack on the same cycle as the issue transition (still IDLE) is also ignored.
- i_evt is accepted in every state, subject to the full rule.

Test Plan:
- Single event: reset, i_evt at cycle 0, i_ack at cycle 10 -> o_req=1 cycles 1-10, o_req=0 and o_done=1 at cycle 11, o_busy=1 until cycle 14, o_busy=0 at cycle 15.
- Burst: i_evt high cycles 0-2 from IDLE, ack each request 3 cycles after its rise -> o_pend=1 at cycle 2 and 2 at cycle 3; three o_req pulses with rises at cycles 1, 10, 19 and o_done after each; final o_pend=0.
- Overflow (CNT_W=2): hold o_req unacked and send 5 events (1 issued, 3 queued) -> fifth event gives o_ovf=1 for one cycle; o_pend stays 3.
- Timeout: i_evt at cycle 0, never ack -> o_req high cycles 1-16, o_timeout=1 at cycle 17, o_done never asserted, IDLE at cycle 21.
- Stray ack and race: i_ack in IDLE and in GAP -> no o_done and no state change. In a separate run, i_ack on the cycle timer==15 -> o_done=1 and o_timeout=0.
- Reset mid-REQ with o_pend=2 -> o_req, o_pend and o_busy go to 0 asynchronously; after release, no request until a new i_evt.

Source files
------------

// File: rtl/pulse_req_sender.sv
// pulse_req_sender: fast-domain initiator for the pulse-synchronizer handshake.
// Local event pulses are queued and each one is issued as a level request.
// A request stays high until the returned single-cycle ack arrives or a timeout
// expires. A low gap between requests lets the far side see every rising edge.
module pulse_req_sender #(
   parameter int CNT_W   = 2,
   parameter int GAP_CYC = 4,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic             f_clk,
   input  logic             frst_n,
   input  logic             i_evt,
   input  logic             i_ack,
   output logic             o_req,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_pend,
   output logic             o_done,
   output logic             o_timeout,
   output logic             o_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Last timer value before a request is abandoned, and last value of the gap.
   localparam logic [TO_W-1:0] LP_TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] LP_GAP_LAST = TO_W'(GAP_CYC - 1);

   state_t           r_state;
   logic [TO_W-1:0]  r_timer;
   logic [CNT_W-1:0] r_pend;
   logic             r_req;
   logic             r_busy;
   logic             r_done;
   logic             r_timeout;
   logic             r_ovf;

   logic             w_issue;
   logic             w_accept;
   logic             w_consume;
   logic             w_full;
   logic             w_drop;
   logic [CNT_W-1:0] w_pendNext;

   // An issue happens only from IDLE. An event that itself triggers the issue
   // from an empty queue goes straight out and is never counted as pending.
   assign w_issue   = (r_state == IDLE) && ((r_pend != '0) || i_evt);
   assign w_accept  = i_evt && !(w_issue && (r_pend == '0));
   assign w_consume = w_issue && (r_pend != '0);
   assign w_full    = &r_pend;
   assign w_drop    = w_accept && w_full && !w_consume;

   // Pending counter next value: saturates at full (event dropped), never
   // wraps below zero, and is unchanged when accept and consume coincide.
   always_comb begin
      w_pendNext = r_pend;
      if (w_accept && !w_consume) begin
         if (!w_full) begin
            w_pendNext = r_pend + CNT_W'(1);
         end
      end else if (!w_accept && w_consume) begin
         w_pendNext = r_pend - CNT_W'(1);
      end
   end

   // Handshake FSM with registered outputs; one timer serves REQ and GAP.
   always_ff @(posedge f_clk or negedge frst_n) begin
      if (!frst_n) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_pend    <= '0;
         r_req     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_ovf     <= w_drop;
         r_pend    <= w_pendNext;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_state <= REQ;
                  r_timer <= '0;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            REQ: begin
               if (i_ack) begin
                  r_state <= GAP;
                  r_timer <= '0;
                  r_req   <= 1'b0;
                  r_done  <= 1'b1;
               end else if (r_timer == LP_TO_LAST) begin
                  r_state   <= GAP;
                  r_timer   <= '0;
                  r_req     <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_timer <= r_timer + TO_W'(1);
               end
            end
            GAP: begin
               if (r_timer == LP_GAP_LAST) begin
                  r_state <= IDLE;
                  r_timer <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_timer <= r_timer + TO_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_timer <= '0;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_req     = r_req;
   assign o_busy    = r_busy;
   assign o_pend    = r_pend;
   assign o_done    = r_done;
   assign o_timeout = r_timeout;
   assign o_ovf     = r_ovf;

endmodule
